key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter N_KEYS, default 4: number of independent key channels.
REQ-002 Parameter STABLE_MS, default 20: consecutive tick count an input must hold its new value before acceptance; legal range 2..255.
REQ-003 Parameter REPEAT_DELAY_MS, default 500: ticks from acceptance of a press to the first repeat pulse; legal range 1..65535.
REQ-004 Parameter REPEAT_RATE_MS, default 100: ticks between subsequent repeat pulses; legal range 1..65535.
REQ-005 clk  input  1  system clock; every flop shall be clocked on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 tick_1ms  input  1  one-clk-wide strobe, nominally once per millisecond, from the existing 1 ms tick generator.
REQ-008 key_raw  input  N_KEYS  asynchronous, bouncing, active-high key inputs.
REQ-009 repeat_en  input  N_KEYS  per-key auto-repeat enable.
REQ-010 key_level  output  N_KEYS  debounced key state.
REQ-011 key_press  output  N_KEYS  one-clk pulse on accepted 0->1 transition.
REQ-012 key_release  output  N_KEYS  one-clk pulse on accepted 1->0 transition.
REQ-013 key_repeat  output  N_KEYS  one-clk auto-repeat pulse while held.

Function
REQ-014 Each key_raw bit shall pass through a 2-flop synchronizer; sync denotes the second flop.
REQ-015 Per-key stability counter, 8 bits: cleared on any clk cycle where sync == key_level, regardless of tick_1ms.
REQ-016 On a cycle with tick_1ms=1 and sync != key_level: if count == STABLE_MS-1, key_level <= sync and count <= 0; otherwise count increments.
REQ-017 key_press/key_release shall be registered and assert exactly in the clk cycle after key_level changes (key_level and pulse both from flops; pulse width 1 clk).
REQ-018 Mismatch cycles without tick shall not advance the counter; a single-cycle return to key_level between ticks shall restart the count from 0.
REQ-019 Acceptance latency: the STABLE_MS-th tick that samples sync != key_level, counted from the first such tick; the raw-to-sync delay is 2 clk.
REQ-020 Per-key state machine: IDLE (level 0) -> PRESS_DLY on accepted press -> REPEATING after REPEAT_DELAY_MS ticks -> stays REPEATING; every state -> IDLE on accepted release.
REQ-021 Repeat counter, 16 bits: cleared on entry to PRESS_DLY and on each repeat pulse; increments on tick_1ms only in PRESS_DLY/REPEATING.
REQ-022 key_repeat pulses when the counter reaches REPEAT_DELAY_MS-1 (PRESS_DLY) or REPEAT_RATE_MS-1 (REPEATING) on a tick, with repeat_en high; the pulse is registered, 1 clk wide.
REQ-023 With repeat_en low, the FSM still sequences but key_repeat is suppressed; raising repeat_en mid-hold resumes pulses at the next counter match, with no catch-up.
REQ-024 Acceptance of a release and a repeat match on the same tick: the release wins; no key_repeat pulse.
REQ-025 The channels are fully independent; simultaneous events on different keys each produce their own pulses in the same cycle.

Reset
REQ-026 While rst_n=0: synchronizers, counters, key_level, key_press, key_release and key_repeat are 0; the FSM is in IDLE.
REQ-027 Reset asserted mid-count or mid-hold aborts without pulses; after release, a held key is re-accepted as a fresh press after STABLE_MS ticks.

Structure
REQ-028 The shared package shall hold the FSM state encoding (IDLE, PRESS_DLY, REPEATING) and counter width constants (8-bit stability, 16-bit repeat).
REQ-029 One sub-module, key_debounce_ch, shall implement a single channel; the top level generates N_KEYS instances and concatenates the outputs.

Verification
REQ-030 Use STABLE_MS=4, REPEAT_DELAY_MS=10, REPEAT_RATE_MS=3, and tick every 10 clk; for the clean-press case, raise key_raw[0] and hold it -> key_level[0]=1 and one key_press[0] pulse on the 4th tick.
REQ-031 Toggle key_raw[1] 1/0 every 7 clk for 100 clk, then hold it at 1 -> no pulses during the bounce, then acceptance 4 ticks after the last edge.
REQ-032 With repeat_en[2]=1, hold key 2 for 30 ticks past acceptance -> key_repeat pulses at +10, +13, +16, ..., +28 ticks (7 pulses); with repeat_en=0, none.
REQ-033 Release key 2 so that acceptance coincides with a repeat match -> key_release pulse only, key_repeat stays 0.
REQ-034 Pull rst_n low 2 ticks into a press count and again while in REPEATING -> all outputs 0 immediately, no pulses; after reset, re-acceptance takes 4 ticks.
REQ-035 Press keys 0 and 3 on the same clk -> key_press=4'b1001 in a single cycle.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debouncer: per-channel FSM encoding and
// counter widths used by every channel instance.
package key_debounce_pkg;

    // Stability counter only has to reach STABLE_MS-1 (at most 254).
    localparam int STAB_CNT_W = 8;

    // Repeat counter has to reach REPEAT_DELAY_MS-1 / REPEAT_RATE_MS-1 (at most 65534).
    localparam int RPT_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_DLY = 2'd1,
        ST_REPEATING = 2'd2
    } key_state_e;

endpackage : key_debounce_pkg

// File: rtl/key_debounce_ch.sv
// Single key channel: synchronizer, tick-based stability filter, press/release
// edge pulses and the auto-repeat sequencer.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | debounced level is 0, nothing to time
// ST_PRESS_DLY | press accepted, timing the initial repeat delay
// ST_REPEATING | first repeat issued, pulsing every REPEAT_RATE_MS ticks
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int unsigned STABLE_MS       = 20,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_1ms,
    input  logic key_raw,
    input  logic repeat_en,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);

    localparam logic [STAB_CNT_W-1:0] STAB_LAST = STAB_CNT_W'(STABLE_MS - 1);
    localparam logic [RPT_CNT_W-1:0]  DLY_LAST  = RPT_CNT_W'(REPEAT_DELAY_MS - 1);
    localparam logic [RPT_CNT_W-1:0]  RATE_LAST = RPT_CNT_W'(REPEAT_RATE_MS - 1);

    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic [STAB_CNT_W-1:0] stab_cnt_q, stab_cnt_d;
    logic                  level_q, level_d;
    logic                  level_dly_q, level_dly_d;
    logic                  press_q, press_d;
    logic                  release_q, release_d;
    logic                  accept;
    logic                  accept_press;
    logic                  accept_release;

    key_state_e            state_q;
    logic [RPT_CNT_W-1:0]  rpt_cnt_q;
    logic                  repeat_q;

    // Next-state for synchronizer, stability filter and edge-pulse generation.
    always_comb begin
        sync1_d     = key_raw;
        sync2_d     = sync1_q;
        stab_cnt_d  = stab_cnt_q;
        level_d     = level_q;
        accept      = 1'b0;

        // Any cycle agreeing with the current level restarts the filter, so a
        // one-cycle glitch back to the old value between ticks costs the whole count.
        if (sync2_q == level_q) begin
            stab_cnt_d = '0;
        end else if (tick_1ms) begin
            if (stab_cnt_q == STAB_LAST) begin
                level_d    = sync2_q;
                stab_cnt_d = '0;
                accept     = 1'b1;
            end else begin
                stab_cnt_d = stab_cnt_q + 1'b1;
            end
        end

        // Pulses come from a delayed copy of the level, so they land in the
        // cycle after the level flop changes.
        level_dly_d = level_q;
        press_d     = level_q & ~level_dly_q;
        release_d   = ~level_q & level_dly_q;
    end

    assign accept_press   = accept & sync2_q;
    assign accept_release = accept & ~sync2_q;

    // Debounce datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            stab_cnt_q  <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            stab_cnt_q  <= stab_cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    // Auto-repeat sequencer; a release accepted on a match tick suppresses that repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rpt_cnt_q <= '0;
            repeat_q  <= 1'b0;
        end else begin
            repeat_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_press) begin
                        state_q   <= ST_PRESS_DLY;
                        rpt_cnt_q <= '0;
                    end
                end
                ST_PRESS_DLY: begin
                    if (accept_release) begin
                        state_q   <= ST_IDLE;
                        rpt_cnt_q <= '0;
                    end else if (tick_1ms) begin
                        if (rpt_cnt_q == DLY_LAST) begin
                            state_q   <= ST_REPEATING;
                            rpt_cnt_q <= '0;
                            repeat_q  <= repeat_en;
                        end else begin
                            rpt_cnt_q <= rpt_cnt_q + 1'b1;
                        end
                    end
                end
                ST_REPEATING: begin
                    if (accept_release) begin
                        state_q   <= ST_IDLE;
                        rpt_cnt_q <= '0;
                    end else if (tick_1ms) begin
                        if (rpt_cnt_q == RATE_LAST) begin
                            rpt_cnt_q <= '0;
                            repeat_q  <= repeat_en;
                        end else begin
                            rpt_cnt_q <= rpt_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    rpt_cnt_q <= '0;
                end
            endcase
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_repeat  = repeat_q;

endmodule : key_debounce_ch

// File: rtl/key_debounce.sv
// Multi-key debouncer top: one independent key_debounce_ch per key, outputs
// gathered back into per-key vectors.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned STABLE_MS       = 20,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_1ms,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic [N_KEYS-1:0] repeat_en,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat
);

    for (genvar g = 0; g < int'(N_KEYS); g++) begin : g_ch
        key_debounce_ch #(
            .STABLE_MS       (STABLE_MS),
            .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
            .REPEAT_RATE_MS  (REPEAT_RATE_MS)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick_1ms    (tick_1ms),
            .key_raw     (key_raw[g]),
            .repeat_en   (repeat_en[g]),
            .key_level   (key_level[g]),
            .key_press   (key_press[g]),
            .key_release (key_release[g]),
            .key_repeat  (key_repeat[g])
        );
    end

endmodule : key_debounce

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short timing parameters and a tick every 10 clk.
module tb_key_debounce;

    localparam int NK = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick_1ms = 1'b0;
    logic [NK-1:0] key_raw = '0;
    logic [NK-1:0] repeat_en = '0;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_repeat;

    int errors = 0;
    int checks = 0;
    int press_cnt[NK]   = '{default: 0};
    int release_cnt[NK] = '{default: 0};
    int repeat_cnt[NK]  = '{default: 0};

    key_debounce #(
        .N_KEYS          (NK),
        .STABLE_MS       (4),
        .REPEAT_DELAY_MS (10),
        .REPEAT_RATE_MS  (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_1ms    (tick_1ms),
        .key_raw     (key_raw),
        .repeat_en   (repeat_en),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_repeat  (key_repeat)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    // Tick strobe: high for one clk out of every 10.
    initial begin
        int phase;
        phase = 0;
        forever begin
            @(negedge clk);
            phase = (phase == 9) ? 0 : phase + 1;
            tick_1ms = (phase == 9);
        end
    end

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < NK; i++) begin
            press_cnt[i]   += int'(key_press[i]);
            release_cnt[i] += int'(key_release[i]);
            repeat_cnt[i]  += int'(key_repeat[i]);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Advance to just after the next clock edge that sees tick_1ms high.
    task automatic tick_edge();
        int guard;
        guard = 0;
        do begin
            @(posedge clk);
            guard++;
        end while (tick_1ms !== 1'b1 && guard < 40);
        if (tick_1ms !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL tick_wait: no tick within %0d clk", guard);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key_raw = '0;
        repeat_en = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (key_level !== 4'b0000) begin errors++; $display("FAIL reset_level: got %b want 0000", key_level); end
        checks++; if (key_press !== 4'b0000) begin errors++; $display("FAIL reset_press: got %b want 0000", key_press); end
        checks++; if (key_release !== 4'b0000) begin errors++; $display("FAIL reset_release: got %b want 0000", key_release); end
        checks++; if (key_repeat !== 4'b0000) begin errors++; $display("FAIL reset_repeat: got %b want 0000", key_repeat); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (key_level !== 4'b0000) begin errors++; $display("FAIL post_reset_level: got %b want 0000", key_level); end
    endtask

    task automatic test_clean_press();
        int p0, r0;
        tick_edge();
        p0 = press_cnt[0];
        r0 = release_cnt[0];
        key_raw[0] = 1'b1;
        repeat (3) tick_edge();
        checks++; if (key_level[0] !== 1'b0) begin errors++; $display("FAIL press_early: level got %b want 0 after 3 ticks", key_level[0]); end
        tick_edge();
        checks++; if (key_level[0] !== 1'b1) begin errors++; $display("FAIL press_accept: level got %b want 1 on 4th tick", key_level[0]); end
        checks++; if (key_press[0] !== 1'b0) begin errors++; $display("FAIL press_same_cycle: got %b want 0", key_press[0]); end
        @(posedge clk); #1;
        checks++; if (key_press[0] !== 1'b1) begin errors++; $display("FAIL press_pulse: got %b want 1", key_press[0]); end
        @(posedge clk); #1;
        checks++; if (key_press[0] !== 1'b0) begin errors++; $display("FAIL press_width: got %b want 0", key_press[0]); end
        repeat (2) @(posedge clk); #1;
        checks++; if (press_cnt[0] - p0 !== 1) begin errors++; $display("FAIL press_count: got %0d want 1", press_cnt[0] - p0); end
        key_raw[0] = 1'b0;
        repeat (3) tick_edge();
        checks++; if (key_level[0] !== 1'b1) begin errors++; $display("FAIL release_early: level got %b want 1", key_level[0]); end
        tick_edge();
        checks++; if (key_level[0] !== 1'b0) begin errors++; $display("FAIL release_accept: level got %b want 0", key_level[0]); end
        repeat (3) @(posedge clk); #1;
        checks++; if (release_cnt[0] - r0 !== 1) begin errors++; $display("FAIL release_count: got %0d want 1", release_cnt[0] - r0); end
        checks++; if (repeat_cnt[0] !== 0) begin errors++; $display("FAIL press_no_repeat: got %0d want 0", repeat_cnt[0]); end
    endtask

    task automatic test_bounce();
        int p1, r1;
        tick_edge();
        repeat (2) @(posedge clk);
        #1;
        p1 = press_cnt[1];
        r1 = release_cnt[1];
        for (int i = 0; i < 14; i++) begin
            key_raw[1] = (i % 2 == 0);
            repeat (7) @(posedge clk);
            #1;
        end
        key_raw[1] = 1'b1;
        checks++; if (key_level[1] !== 1'b0) begin errors++; $display("FAIL bounce_level: got %b want 0", key_level[1]); end
        checks++; if (press_cnt[1] - p1 !== 0) begin errors++; $display("FAIL bounce_press: got %0d pulses want 0", press_cnt[1] - p1); end
        checks++; if (release_cnt[1] - r1 !== 0) begin errors++; $display("FAIL bounce_release: got %0d pulses want 0", release_cnt[1] - r1); end
        repeat (3) tick_edge();
        checks++; if (key_level[1] !== 1'b0) begin errors++; $display("FAIL bounce_early: got %b want 0 after 3 ticks", key_level[1]); end
        tick_edge();
        checks++; if (key_level[1] !== 1'b1) begin errors++; $display("FAIL bounce_accept: got %b want 1 on 4th tick", key_level[1]); end
        repeat (3) @(posedge clk); #1;
        checks++; if (press_cnt[1] - p1 !== 1) begin errors++; $display("FAIL bounce_press_count: got %0d want 1", press_cnt[1] - p1); end
        key_raw[1] = 1'b0;
        repeat (4) tick_edge();
        repeat (3) @(posedge clk); #1;
        checks++; if (release_cnt[1] - r1 !== 1) begin errors++; $display("FAIL bounce_release_count: got %0d want 1", release_cnt[1] - r1); end
    endtask

    task automatic test_repeat();
        int rp;
        logic exp;
        tick_edge();
        key_raw[2] = 1'b1;
        repeat_en[2] = 1'b1;
        repeat (4) tick_edge();
        checks++; if (key_level[2] !== 1'b1) begin errors++; $display("FAIL repeat_accept: got %b want 1", key_level[2]); end
        rp = repeat_cnt[2];
        for (int k = 1; k <= 30; k++) begin
            tick_edge();
            exp = (k >= 10) && ((k - 10) % 3 == 0);
            checks++; if (key_repeat[2] !== exp) begin errors++; $display("FAIL repeat_tick%0d: got %b want %b", k, key_repeat[2], exp); end
        end
        repeat (2) @(posedge clk); #1;
        checks++; if (repeat_cnt[2] - rp !== 7) begin errors++; $display("FAIL repeat_count: got %0d want 7", repeat_cnt[2] - rp); end
        // Release so acceptance falls on tick +34, itself a repeat match.
        key_raw[2] = 1'b0;
        tick_edge();
        checks++; if (key_repeat[2] !== 1'b1) begin errors++; $display("FAIL repeat_tick31: got %b want 1", key_repeat[2]); end
        repeat (2) tick_edge();
        checks++; if (key_level[2] !== 1'b1) begin errors++; $display("FAIL race_early: level got %b want 1", key_level[2]); end
        tick_edge();
        checks++; if (key_level[2] !== 1'b0) begin errors++; $display("FAIL race_level: got %b want 0", key_level[2]); end
        checks++; if (key_repeat[2] !== 1'b0) begin errors++; $display("FAIL race_repeat: got %b want 0", key_repeat[2]); end
        @(posedge clk); #1;
        checks++; if (key_release[2] !== 1'b1) begin errors++; $display("FAIL race_release: got %b want 1", key_release[2]); end
        repeat (3) @(posedge clk); #1;
        checks++; if (repeat_cnt[2] - rp !== 8) begin errors++; $display("FAIL race_repeat_count: got %0d want 8", repeat_cnt[2] - rp); end
    endtask

    task automatic test_repeat_gate();
        int rp;
        logic exp;
        repeat_en[2] = 1'b0;
        tick_edge();
        key_raw[2] = 1'b1;
        repeat (4) tick_edge();
        checks++; if (key_level[2] !== 1'b1) begin errors++; $display("FAIL gate_accept: got %b want 1", key_level[2]); end
        rp = repeat_cnt[2];
        for (int k = 1; k <= 30; k++) begin
            tick_edge();
            exp = (k >= 22) && ((k - 22) % 3 == 0);
            checks++; if (key_repeat[2] !== exp) begin errors++; $display("FAIL gate_tick%0d: got %b want %b", k, key_repeat[2], exp); end
            if (k == 20) repeat_en[2] = 1'b1;
        end
        key_raw[2] = 1'b0;
        repeat_en[2] = 1'b0;
        repeat (5) tick_edge();
        checks++; if (key_level[2] !== 1'b0) begin errors++; $display("FAIL gate_release: got %b want 0", key_level[2]); end
        checks++; if (repeat_cnt[2] - rp !== 3) begin errors++; $display("FAIL gate_count: got %0d want 3", repeat_cnt[2] - rp); end
    endtask

    task automatic test_reset_abort();
        int p0, rp;
        logic exp;
        tick_edge();
        key_raw[0] = 1'b1;
        p0 = press_cnt[0];
        repeat (2) tick_edge();
        rst_n = 1'b0;
        #1;
        checks++; if (key_level !== 4'b0000) begin errors++; $display("FAIL abort1_level: got %b want 0000", key_level); end
        repeat (25) @(posedge clk);
        tick_edge();
        rst_n = 1'b1;
        repeat (3) tick_edge();
        checks++; if (key_level[0] !== 1'b0) begin errors++; $display("FAIL abort1_early: got %b want 0 after 3 ticks", key_level[0]); end
        tick_edge();
        checks++; if (key_level[0] !== 1'b1) begin errors++; $display("FAIL abort1_accept: got %b want 1", key_level[0]); end
        @(posedge clk); #1;
        checks++; if (key_press[0] !== 1'b1) begin errors++; $display("FAIL abort1_press: got %b want 1", key_press[0]); end
        repeat (2) @(posedge clk); #1;
        checks++; if (press_cnt[0] - p0 !== 1) begin errors++; $display("FAIL abort1_count: got %0d want 1", press_cnt[0] - p0); end
        key_raw[0] = 1'b0;
        repeat (5) tick_edge();

        key_raw[2] = 1'b1;
        repeat_en[2] = 1'b1;
        repeat (4) tick_edge();
        checks++; if (key_level[2] !== 1'b1) begin errors++; $display("FAIL abort2_accept: got %b want 1", key_level[2]); end
        repeat (12) tick_edge();
        rp = repeat_cnt[2];
        rst_n = 1'b0;
        #1;
        checks++; if (key_level !== 4'b0000) begin errors++; $display("FAIL abort2_level: got %b want 0000", key_level); end
        checks++; if (key_repeat !== 4'b0000) begin errors++; $display("FAIL abort2_repeat: got %b want 0000", key_repeat); end
        repeat (40) @(posedge clk);
        tick_edge();
        checks++; if (repeat_cnt[2] - rp !== 0) begin errors++; $display("FAIL abort2_no_pulse: got %0d want 0", repeat_cnt[2] - rp); end
        rst_n = 1'b1;
        repeat (3) tick_edge();
        checks++; if (key_level[2] !== 1'b0) begin errors++; $display("FAIL abort2_early: got %b want 0", key_level[2]); end
        tick_edge();
        checks++; if (key_level[2] !== 1'b1) begin errors++; $display("FAIL abort2_reaccept: got %b want 1", key_level[2]); end
        @(posedge clk); #1;
        checks++; if (key_press[2] !== 1'b1) begin errors++; $display("FAIL abort2_press: got %b want 1", key_press[2]); end
        for (int k = 1; k <= 10; k++) begin
            tick_edge();
            exp = (k == 10);
            checks++; if (key_repeat[2] !== exp) begin errors++; $display("FAIL abort2_tick%0d: got %b want %b", k, key_repeat[2], exp); end
        end
        key_raw[2] = 1'b0;
        repeat_en[2] = 1'b0;
        repeat (5) tick_edge();
    endtask

    task automatic test_simultaneous();
        tick_edge();
        key_raw = 4'b1001;
        repeat (4) tick_edge();
        checks++; if (key_level !== 4'b1001) begin errors++; $display("FAIL simul_level: got %b want 1001", key_level); end
        @(posedge clk); #1;
        checks++; if (key_press !== 4'b1001) begin errors++; $display("FAIL simul_press: got %b want 1001", key_press); end
        @(posedge clk); #1;
        checks++; if (key_press !== 4'b0000) begin errors++; $display("FAIL simul_press_end: got %b want 0000", key_press); end
        key_raw = 4'b0000;
        repeat (4) tick_edge();
        checks++; if (key_level !== 4'b0000) begin errors++; $display("FAIL simul_rel_level: got %b want 0000", key_level); end
        @(posedge clk); #1;
        checks++; if (key_release !== 4'b1001) begin errors++; $display("FAIL simul_release: got %b want 1001", key_release); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat();
        test_repeat_gate();
        test_reset_abort();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_key_debounce
